// File: rtl/nn_stream_pkg.sv
// Shared definitions for the network's serial-to-parallel stream stages.
//   stream_state_e : collect/discard state encoding
//   cnt_w()        : element-counter width for a frame of n elements
package nn_stream_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      DISCARD = 1'b1
   } stream_state_e;

   // Counter width max(1, clog2(n)); n=1 still needs a 1-bit counter.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : nn_stream_pkg

// File: rtl/layer_out_packer.sv
// Packs one layer's serially arriving neuron outputs into the parallel
// vector consumed by the argmax stage, dropping malformed frames.
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   s_data    : one neuron output (carried bit-exact)
//   s_valid   : beat strobe, always accepted
//   s_last    : final element of a frame, qualified by s_valid
//   dout      : packed vector, element k at [(k+1)*inputWidth-1 : k*inputWidth]
//   dout_vld  : one-cycle pulse, dout holds a new complete frame
//   frame_err : one-cycle pulse, a short or long frame was dropped
//   frame_cnt : count of good frames emitted, wraps
module layer_out_packer
   import nn_stream_pkg::*;
#(
   parameter int unsigned numInput   = 10,
   parameter int unsigned inputWidth = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [inputWidth-1:0]          s_data,
   input  logic                           s_valid,
   input  logic                           s_last,
   output logic [numInput*inputWidth-1:0] dout,
   output logic                           dout_vld,
   output logic                           frame_err,
   output logic [15:0]                    frame_cnt
);

   localparam int unsigned CNT_W = cnt_w(numInput);
   localparam int unsigned VEC_W = numInput * inputWidth;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(numInput - 1);

   stream_state_e    state;
   logic [CNT_W-1:0] cnt;
   logic [VEC_W-1:0] asm_q;
   logic [VEC_W-1:0] asm_c;

   // Shadow assembly with the current beat written into slice cnt.
   always_comb begin
      asm_c = asm_q;
      for (int k = 0; k < int'(numInput); k++) begin
         if (cnt == CNT_W'(k)) begin
            asm_c[k*inputWidth +: inputWidth] = s_data;
         end
      end
   end

   // Frame FSM, element counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= COLLECT;
         cnt       <= '0;
         asm_q     <= '0;
         dout      <= '0;
         dout_vld  <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
      end else begin
         dout_vld  <= 1'b0;
         frame_err <= 1'b0;
         if (s_valid) begin
            case (state)
               COLLECT: begin
                  if (cnt == LAST_IDX) begin
                     cnt <= '0;
                     if (s_last) begin
                        dout      <= asm_c;
                        dout_vld  <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                     end else begin
                        // Long frame: flag once, then swallow up to s_last.
                        frame_err <= 1'b1;
                        state     <= DISCARD;
                     end
                  end else if (s_last) begin
                     cnt       <= '0;
                     frame_err <= 1'b1;
                  end else begin
                     asm_q <= asm_c;
                     cnt   <= cnt + CNT_W'(1);
                  end
               end
               DISCARD: begin
                  if (s_last) begin
                     state <= COLLECT;
                  end
               end
               default: state <= COLLECT;
            endcase
         end
      end
   end

endmodule : layer_out_packer
